// File: rtl/dm_responder_if.sv
// Load/store bundle between a CPU data port (master) and the memory responder (slave).
// req_wstrb only exists when DM_BYTE_STROBE_EN is defined.
interface dm_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
`ifdef DM_BYTE_STROBE_EN
  logic [3:0]  req_wstrb;
`endif
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
`ifdef DM_BYTE_STROBE_EN
    output req_wstrb,
`endif
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
`ifdef DM_BYTE_STROBE_EN
    input  req_wstrb,
`endif
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency, error on bad address.
// Optional DM_BYTE_STROBE_EN enables per-byte store lanes via req_wstrb.
module dm_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  dm_responder_if.slave bus
);
  localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          write_q, write_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
`ifdef DM_BYTE_STROBE_EN
  logic [3:0]    wstrb_q, wstrb_d;
`endif

  logic [31:0]   mem [DEPTH_WORDS];
  logic          addr_err;
  logic          access;
  logic          mem_we;
  logic [IW-1:0] idx;
  logic [31:0]   wr_word;

  // The full upper address is range-checked so high bits never alias into the array.
  assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH_WORDS));
  assign idx      = addr_q[IW+1:2];
  assign access   = (state_q == WAIT) && (cnt_q == CW'(WAIT_CYCLES));
  assign mem_we   = access && write_q && !addr_err;

`ifdef DM_BYTE_STROBE_EN
  always_comb begin
    wr_word = mem[idx];
    for (int i = 0; i < 4; i++) begin
      if (wstrb_q[i]) wr_word[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end
`else
  assign wr_word = wdata_q;
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wr_word;
  end

  // WAIT always lasts WAIT_CYCLES+1 cycles; its last cycle is the access slot.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
`ifdef DM_BYTE_STROBE_EN
    wstrb_d = wstrb_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
`ifdef DM_BYTE_STROBE_EN
          wstrb_d = bus.req_wstrb;
`endif
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (access) begin
          state_d = RESP;
          err_d   = addr_err;
          rdata_d = (!write_q && !addr_err) ? mem[idx] : 32'h0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
          rdata_d = 32'h0;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef DM_BYTE_STROBE_EN
      wstrb_q <= 4'h0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef DM_BYTE_STROBE_EN
      wstrb_q <= wstrb_d;
`endif
    end
  end

  assign bus.req_ready  = rst_n && (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: transaction-level memory model plus directed literal checks.
// Build with DM_BYTE_STROBE_EN defined to also exercise byte-lane stores.
module tb_dm_responder;
  localparam int WAIT_A = 2;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dm_responder_if bus_a();
  dm_responder_if bus_b();

  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  dm_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic failTimeout(input string name);
    n_tests++;
    n_fail++;
    $display("[TB] FAIL %s: got timeout expected handshake (t=%0t)", name, $time);
  endtask

  function automatic logic [31:0] mergeStore(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] strb);
    logic [31:0] m;
    m = new_w;
`ifdef DM_BYTE_STROBE_EN
    for (int i = 0; i < 4; i++) m[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
`else
    if (strb == 4'hF) m = new_w;
    else m = new_w | (old_w & 32'h0);
`endif
    return m;
  endfunction

  // Transaction-level model of instance A: one outstanding access, due a fixed number of
  // edges after acceptance; a pending store only lands in the model when its slot arrives.
  logic [31:0] model_mem [DEPTH];
  bit          mdl_busy = 1'b0;
  int          mdl_due = 0;
  logic [31:0] mdl_rdata = 32'h0;
  logic        mdl_err = 1'b0;
  bit          mdl_we = 1'b0;
  int          mdl_idx = 0;
  logic [31:0] mdl_word = 32'h0;
  logic [31:0] mdl_addr;
  logic [3:0]  mdl_strb;
  bit          exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_req_ready", 32'(bus_a.req_ready), 32'h0);
      checkOutput("rst_resp_valid", 32'(bus_a.resp_valid), 32'h0);
      checkOutput("rst_rdata", bus_a.resp_rdata, 32'h0);
      checkOutput("rst_err", 32'(bus_a.resp_err), 32'h0);
      mdl_busy = 1'b0;
      mdl_we   = 1'b0;
    end else begin
      exp_v = mdl_busy && (cyc >= mdl_due);
      if (exp_v && mdl_we) begin
        model_mem[mdl_idx] = mdl_word;
        mdl_we = 1'b0;
      end
      checkOutput("mon_req_ready", 32'(bus_a.req_ready), 32'(!mdl_busy));
      checkOutput("mon_resp_valid", 32'(bus_a.resp_valid), 32'(exp_v));
      checkOutput("mon_rdata", bus_a.resp_rdata, exp_v ? mdl_rdata : 32'h0);
      checkOutput("mon_err", 32'(bus_a.resp_err), exp_v ? 32'(mdl_err) : 32'h0);
      if (exp_v && bus_a.resp_ready) begin
        mdl_busy = 1'b0;
      end else if (!mdl_busy && bus_a.req_valid) begin
        mdl_addr = bus_a.req_addr;
`ifdef DM_BYTE_STROBE_EN
        mdl_strb = bus_a.req_wstrb;
`else
        mdl_strb = 4'hF;
`endif
        mdl_busy = 1'b1;
        mdl_due  = cyc + 2 + WAIT_A;
        mdl_err  = (mdl_addr % 4 != 0) || (mdl_addr / 4 >= DEPTH);
        mdl_idx  = int'(mdl_addr[9:2]);
        if (bus_a.req_write) begin
          mdl_rdata = 32'h0;
          mdl_we    = !mdl_err;
          mdl_word  = mergeStore(model_mem[mdl_idx], bus_a.req_wdata, mdl_strb);
        end else begin
          mdl_rdata = mdl_err ? 32'h0 : model_mem[mdl_idx];
          mdl_we    = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input int hold, input bit noise,
                               output logic [31:0] rdata, output logic err, output int lat);
    int acc;
    bit ok;
    rdata = 32'h0;
    err   = 1'b0;
    lat   = -1;
    bus_a.req_write = wr;
    bus_a.req_addr  = addr;
    bus_a.req_wdata = wdata;
`ifdef DM_BYTE_STROBE_EN
    bus_a.req_wstrb = strb;
`endif
    bus_a.req_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus_a.req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      failTimeout("req_accept");
      bus_a.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    bus_a.req_valid = 1'b0;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus_a.resp_valid) begin
        ok = 1'b1;
        break;
      end
      if (noise) begin
        bus_a.req_valid = 1'($urandom_range(0, 1));
        bus_a.req_write = 1'($urandom_range(0, 1));
        bus_a.req_addr  = $urandom;
      end
      @(posedge clk); #1;
    end
    bus_a.req_valid = 1'b0;
    if (!ok) begin
      failTimeout("resp_valid");
      return;
    end
    lat   = cyc - acc;
    rdata = bus_a.resp_rdata;
    err   = bus_a.resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
    end
    bus_a.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus_a.resp_ready = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  logic [31:0] ra;
  int          rsel;
  int          acc_b;
  int          prev_b;
  bit          ok_b;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus_a.req_valid = 0; bus_a.req_write = 0; bus_a.req_addr = 0; bus_a.req_wdata = 0;
    bus_a.resp_ready = 0;
    bus_b.req_valid = 0; bus_b.req_write = 0; bus_b.req_addr = 0; bus_b.req_wdata = 0;
    bus_b.resp_ready = 1;
`ifdef DM_BYTE_STROBE_EN
    bus_a.req_wstrb = 4'hF;
    bus_b.req_wstrb = 4'hF;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_req_ready", 32'(bus_a.req_ready), 32'h1);

    for (int k = 0; k < 16; k++)
      applyStimulus(1'b1, 32'(4 * k), 32'hA500_0000 | 32'(k), 4'hF, 0, 1'b0, rd, er, lat);
    applyStimulus(1'b1, 32'h3FC, 32'hA500_00FF, 4'hF, 0, 1'b0, rd, er, lat);

    applyStimulus(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t1_store_lat", 32'(lat), 32'd3);
    checkOutput("t1_store_rdata", rd, 32'h0);
    applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t1_load_lat", 32'(lat), 32'd3);
    checkOutput("t1_load_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("t1_load_err", 32'(er), 32'h0);

    applyStimulus(1'b0, 32'h13, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t2_misaligned_err", 32'(er), 32'h1);
    checkOutput("t2_misaligned_rdata", rd, 32'h0);
    applyStimulus(1'b1, 32'h400, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t2_range_err", 32'(er), 32'h1);
    checkOutput("t2_range_lat", 32'(lat), 32'd3);
    applyStimulus(1'b0, 32'h0, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t2_word0_unchanged", rd, 32'hA500_0000);
    applyStimulus(1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t2_no_wrap_err", 32'(er), 32'h1);
    applyStimulus(1'b0, 32'h3FC, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t2_last_word", rd, 32'hA500_00FF);

    applyStimulus(1'b0, 32'h14, 32'h0, 4'hF, 5, 1'b1, rd, er, lat);
    checkOutput("t3_hold_rdata", rd, 32'hA500_0005);

    applyStimulus(1'b1, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    bus_a.req_write = 1'b1; bus_a.req_addr = 32'h20; bus_a.req_wdata = 32'h1234;
`ifdef DM_BYTE_STROBE_EN
    bus_a.req_wstrb = 4'hF;
`endif
    bus_a.req_valid = 1'b1;
    ok_b = 1'b0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (bus_a.req_ready) begin
        ok_b = 1'b1;
        break;
      end
    end
    if (!ok_b) failTimeout("t4_accept");
    @(posedge clk); #1;
    bus_a.req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t4_rst_resp_valid", 32'(bus_a.resp_valid), 32'h0);
    checkOutput("t4_rst_req_ready", 32'(bus_a.req_ready), 32'h0);
    checkOutput("t4_rst_rdata", bus_a.resp_rdata, 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t4_store_aborted", rd, 32'h0);

`ifdef DM_BYTE_STROBE_EN
    applyStimulus(1'b1, 32'h8, 32'h1122_3344, 4'hF, 0, 1'b0, rd, er, lat);
    applyStimulus(1'b1, 32'h8, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, rd, er, lat);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t6_strobe_merge", rd, 32'h11BB_33DD);
    applyStimulus(1'b1, 32'h8, 32'hFFFF_FFFF, 4'h0, 0, 1'b0, rd, er, lat);
    checkOutput("t6_zero_strb_err", 32'(er), 32'h0);
    applyStimulus(1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0, rd, er, lat);
    checkOutput("t6_zero_strb_keep", rd, 32'h11BB_33DD);
`endif

    for (int i = 0; i < 60; i++) begin
      rsel = $urandom_range(0, 9);
      case (rsel)
        6:       ra = 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
        7:       ra = 32'(32'h400 + 4 * $urandom_range(0, 255));
        8:       ra = 32'h8000_0000 | 32'(4 * $urandom_range(0, 15));
        9:       ra = 32'h3FC;
        default: ra = 32'(4 * $urandom_range(0, 15));
      endcase
      applyStimulus(1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), 1'b1, rd, er, lat);
      checkOutput("rand_latency", 32'(lat), 32'd3);
    end

    @(posedge clk); #1;
    bus_b.req_write = 1'b0;
    bus_b.req_addr  = 32'h0;
    bus_b.req_valid = 1'b1;
    prev_b = 0;
    for (int k = 0; k < 4; k++) begin
      ok_b = 1'b0;
      for (int t = 0; t < 10; t++) begin
        @(negedge clk);
        if (bus_b.req_ready) begin
          ok_b = 1'b1;
          break;
        end
      end
      if (!ok_b) begin
        failTimeout("t5_accept");
        break;
      end
      acc_b = cyc + 1;
      @(posedge clk); #1;
      checkOutput("t5_valid_at_accept", 32'(bus_b.resp_valid), 32'h0);
      bus_b.req_addr = 32'(4 * (k + 1));
      @(posedge clk); #1;
      checkOutput("t5_valid_one_edge", 32'(bus_b.resp_valid), 32'h1);
      checkOutput("t5_err", 32'(bus_b.resp_err), 32'h0);
      if (k > 0) checkOutput("t5_spacing", 32'(acc_b - prev_b), 32'd3);
      prev_b = acc_b;
    end
    bus_b.req_valid = 1'b0;

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
